// File: rtl/intr_pkg.sv
// Shared types and constants for the interrupt controller slice.
// Holds the controller state enum and the machine-external-interrupt cause base.
package intr_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        TAKE,
        SERVICE
    } state_t;

    localparam logic [31:0] MCAUSE_BASE = 32'h8000_0010;

endpackage

// File: rtl/intr_ctrl_if.sv
// Bus bundle between the interrupt controller and the core/CSR side.
// slave: controller view (requests in, trap info out); master: core view.
interface intr_ctrl_if #(
    parameter int NUM_IRQ = 4
);
    localparam int IW = $clog2(NUM_IRQ);

    logic [NUM_IRQ-1:0] IRQ;
    logic               MIE;
    logic               INSTR_DONE;
    logic               mret_exec;
    logic               INT_TAKEN;
    logic [IW-1:0]      INT_ID;
    logic [31:0]        MCAUSE;
    logic [NUM_IRQ-1:0] PENDING;
    logic               IN_ISR;

    modport master (
        output IRQ, MIE, INSTR_DONE, mret_exec,
        input  INT_TAKEN, INT_ID, MCAUSE, PENDING, IN_ISR
    );

    modport slave (
        input  IRQ, MIE, INSTR_DONE, mret_exec,
        output INT_TAKEN, INT_ID, MCAUSE, PENDING, IN_ISR
    );

endinterface

// File: rtl/intr_arb.sv
// Combinational arbiter: first pending source found scanning up from i_ptr.
// Ports: i_pend, i_ptr in; o_gnt (one-hot), o_idx out. i_ptr=0 gives fixed priority.
module intr_arb #(
    parameter int NUM_IRQ = 4,
    parameter int IW      = $clog2(NUM_IRQ)
) (
    input  logic [NUM_IRQ-1:0] i_pend,
    input  logic [IW-1:0]      i_ptr,
    output logic [NUM_IRQ-1:0] o_gnt,
    output logic [IW-1:0]      o_idx
);

    logic        w_found;
    logic [IW:0] w_k;

    always_comb begin
        o_gnt   = '0;
        o_idx   = '0;
        w_found = 1'b0;
        w_k     = '0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            // wrap ptr+i back into 0..NUM_IRQ-1
            w_k = {1'b0, i_ptr} + (IW+1)'(i);
            if (w_k >= (IW+1)'(NUM_IRQ))
                w_k = w_k - (IW+1)'(NUM_IRQ);
            if (!w_found && i_pend[w_k[IW-1:0]]) begin
                o_gnt[w_k[IW-1:0]] = 1'b1;
                o_idx              = w_k[IW-1:0];
                w_found            = 1'b1;
            end
        end
    end

endmodule

// File: rtl/intr_ctrl.sv
// Edge-triggered interrupt controller: pending latch, arbitration, trap FSM.
// Ports: CLK, RST (async high), bus (intr_ctrl_if.slave). Macro INTR_RR_EN: round-robin.
module intr_ctrl
    import intr_pkg::*;
#(
    parameter int NUM_IRQ = 4
) (
    input  logic        CLK,
    input  logic        RST,
    intr_ctrl_if.slave  bus
);

    localparam int IW = $clog2(NUM_IRQ);

    state_t             r_state;
    logic [NUM_IRQ-1:0] r_irq_q;
    logic [NUM_IRQ-1:0] r_pend;
    logic               r_live;
    logic               r_taken;
    logic               r_isr;
    logic [IW-1:0]      r_id;

    logic [NUM_IRQ-1:0] w_edge;
    logic [NUM_IRQ-1:0] w_gnt;
    logic [NUM_IRQ-1:0] w_clr;
    logic [IW-1:0]      w_idx;
    logic [IW-1:0]      w_ptr;
    logic               w_take;

`ifdef INTR_RR_EN
    logic [IW-1:0] r_ptr;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            r_ptr <= '0;
        else if (w_take)
            r_ptr <= (w_idx == IW'(NUM_IRQ-1)) ? '0 : w_idx + IW'(1);
    end

    assign w_ptr = r_ptr;
`else
    assign w_ptr = '0;
`endif

    intr_arb #(
        .NUM_IRQ (NUM_IRQ),
        .IW      (IW)
    ) u_arb (
        .i_pend (r_pend),
        .i_ptr  (w_ptr),
        .o_gnt  (w_gnt),
        .o_idx  (w_idx)
    );

    // r_live masks the first sampled cycle after reset so lines
    // already high at release are not mistaken for fresh edges.
    assign w_edge = bus.IRQ & ~r_irq_q & {NUM_IRQ{r_live}};
    assign w_take = (r_state == ARMED) && bus.MIE
                 && (|r_pend) && bus.INSTR_DONE;
    assign w_clr  = w_take ? w_gnt : '0;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_irq_q <= '0;
            r_pend  <= '0;
            r_live  <= 1'b0;
        end else begin
            r_irq_q <= bus.IRQ;
            r_live  <= 1'b1;
            // a new edge on the granted source wins over the clear
            r_pend  <= (r_pend & ~w_clr) | w_edge;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= IDLE;
            r_taken <= 1'b0;
            r_isr   <= 1'b0;
            r_id    <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if ((|r_pend) && bus.MIE)
                        r_state <= ARMED;
                end
                ARMED: begin
                    if (!bus.MIE || !(|r_pend)) begin
                        r_state <= IDLE;
                    end else if (w_take) begin
                        r_state <= TAKE;
                        r_taken <= 1'b1;
                        r_isr   <= 1'b1;
                        r_id    <= w_idx;
                    end
                end
                TAKE: begin
                    r_state <= SERVICE;
                    r_taken <= 1'b0;
                end
                SERVICE: begin
                    if (bus.mret_exec) begin
                        r_state <= IDLE;
                        r_isr   <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_taken <= 1'b0;
                    r_isr   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.INT_TAKEN = r_taken;
    assign bus.IN_ISR    = r_isr;
    assign bus.INT_ID    = r_id;
    assign bus.PENDING   = r_pend;
    assign bus.MCAUSE    = MCAUSE_BASE + 32'(r_id);

endmodule
